// File: rtl/sr_cmd_conditioner_pkg.sv
// rtl/sr_cmd_conditioner_pkg.sv - shared constants, types and arbitration rule for the SR command conditioner
package sr_cmd_conditioner_pkg;

    localparam int DEB_CYCLES_DEF = 4;
    localparam int CNT_W_DEF      = 3;

    typedef struct packed {
        logic s;
        logic r;
        logic conflict;
    } cmd_out_t;

    // Clear wins a tie; the losing set request is discarded rather than deferred.
    function automatic cmd_out_t arbitrate(input logic req_set, input logic req_clr);
        cmd_out_t c;
        c.r        = req_clr;
        c.s        = req_set & ~req_clr;
        c.conflict = req_set & req_clr;
        return c;
    endfunction

endpackage

// File: rtl/sr_cmd_conditioner_deb_channel.sv
// rtl/sr_cmd_conditioner_deb_channel.sv - per-button synchroniser, debouncer and rising-edge request
module sr_cmd_conditioner_deb_channel
    import sr_cmd_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_lvl,
    output logic o_req
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lvl;
    logic             r_lvl_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only runs while the synchronised input disagrees with the
    // accepted level, so it stays bounded by CNT_MAX and never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
        end else begin
            r_lvl_d <= r_lvl;
            if (r_sync2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_lvl <= ~r_lvl;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_lvl = r_lvl;
    assign o_req = r_lvl & ~r_lvl_d;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// rtl/sr_cmd_conditioner.sv - debounced, arbitrated one-cycle set/clear pulses for an SR flip-flop
module sr_cmd_conditioner
    import sr_cmd_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_set,
    input  logic i_btn_clr,
    output logic o_s,
    output logic o_r,
    output logic o_conflict,
    output logic o_lvl_set,
    output logic o_lvl_clr
);

    logic     w_req_set;
    logic     w_req_clr;
    cmd_out_t r_out;

    sr_cmd_conditioner_deb_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deb_set (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_set),
        .o_lvl   (o_lvl_set),
        .o_req   (w_req_set)
    );

    sr_cmd_conditioner_deb_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deb_clr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_clr),
        .o_lvl   (o_lvl_clr),
        .o_req   (w_req_clr)
    );

    // Registered so s and r are glitch-free and mutually exclusive at the FF pins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= arbitrate(w_req_set, w_req_clr);
        end
    end

    assign o_s        = r_out.s;
    assign o_r        = r_out.r;
    assign o_conflict = r_out.conflict;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// tb/tb_sr_cmd_conditioner.sv - self-checking bench for sr_cmd_conditioner
module tb_sr_cmd_conditioner;

    localparam int D = 4;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_btn_set = 1'b0;
    logic i_btn_clr = 1'b0;
    logic o_s, o_r, o_conflict, o_lvl_set, o_lvl_clr;

    int n_checks = 0;
    int n_fail = 0;

    sr_cmd_conditioner #(.DEB_CYCLES(D), .CNT_W(3)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_btn_set  (i_btn_set),
        .i_btn_clr  (i_btn_clr),
        .o_s        (o_s),
        .o_r        (o_r),
        .o_conflict (o_conflict),
        .o_lvl_set  (o_lvl_set),
        .o_lvl_clr  (o_lvl_clr)
    );

    always #5 i_clk = ~i_clk;

    wire [4:0] w_out = {o_s, o_r, o_conflict, o_lvl_set, o_lvl_clr};

    // Reference: a level is accepted once the last D synchronised samples
    // (raw samples delayed two edges) all disagree with the current level.
    bit       hist [2][0:D+1];
    bit       m_lvl [2];
    bit       m_lvl_prev [2];
    logic [4:0] m_out;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < D + 2; j++) hist[c][j] = 1'b0;
            m_lvl[c] = 1'b0;
            m_lvl_prev[c] = 1'b0;
        end
        m_out = '0;
    endfunction

    function automatic void model_edge(input bit set, input bit clr);
        bit req [2];
        bit raw [2];
        bit stable;
        raw[0] = set;
        raw[1] = clr;
        for (int c = 0; c < 2; c++) begin
            for (int j = D + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = raw[c];
            req[c] = m_lvl[c] && !m_lvl_prev[c];
            stable = 1'b1;
            for (int j = 0; j < D; j++) if (hist[c][2+j] == m_lvl[c]) stable = 1'b0;
            m_lvl_prev[c] = m_lvl[c];
            if (stable) m_lvl[c] = !m_lvl[c];
        end
        m_out = {req[0] && !req[1], req[1], req[0] && req[1], m_lvl[0], m_lvl[1]};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic set, input logic clr);
        i_btn_set = set;
        i_btn_clr = clr;
        @(posedge i_clk);
        model_edge(set, clr);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_btn_set = 1'b0;
        i_btn_clr = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       set;
        logic       clr;
        logic [4:0] exp;   // {s, r, conflict, lvl_set, lvl_clr}
    } vec_t;

    vec_t vecs [32];
    int   pulses;

    initial begin
        for (int i = 0; i < 32; i++) begin
            vecs[i].exp = '0;
            if (i < 8) begin
                vecs[i].set = 1; vecs[i].clr = 0;
                vecs[i].exp[1] = (i >= 5);
                vecs[i].exp[4] = (i == 6);
            end else if (i < 16) begin
                vecs[i].set = 1; vecs[i].clr = 1;
                vecs[i].exp[1] = 1'b1;
                vecs[i].exp[0] = (i >= 13);
                vecs[i].exp[3] = (i == 14);
            end else if (i < 24) begin
                vecs[i].set = 0; vecs[i].clr = 0;
                vecs[i].exp[1] = (i < 21);
                vecs[i].exp[0] = (i < 21);
            end else begin
                vecs[i].set = 1; vecs[i].clr = 1;
                vecs[i].exp[1] = (i >= 29);
                vecs[i].exp[0] = (i >= 29);
                vecs[i].exp[3] = (i == 30);
                vecs[i].exp[2] = (i == 30);
            end
        end

        // Reset hold with both buttons pressed
        i_rst_n = 1'b0;
        i_btn_set = 1'b1;
        i_btn_clr = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            chk("reset_hold", w_out, 5'b0);
        end
        do_reset();

        // Directed table: clean set press, clear press while set held, release, coincident press
        for (int i = 0; i < 32; i++) begin
            step(vecs[i].set, vecs[i].clr);
            chk($sformatf("table_row%0d", i), w_out, vecs[i].exp);
        end

        // Bounce on clear, then steady: single r pulse 7 edges after steady begins
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, (i < 4) ? ((i % 2) == 0) : 1'b1);
            chk($sformatf("bounce_r%0d", i), {4'b0, o_r}, {4'b0, (i == 10)});
        end

        // Three-cycle glitch never accepted
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(i < 3, 1'b0);
            chk($sformatf("glitch%0d", i), {3'b0, o_s, o_lvl_set}, 5'b0);
        end

        // Asynchronous reset mid-debounce with set still held
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_reset_async", w_out, 5'b0);
        @(posedge i_clk);
        #1;
        chk("mid_reset_hold", w_out, 5'b0);
        i_rst_n = 1'b1;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0);
            chk($sformatf("post_reset_s%0d", i), {4'b0, o_s}, {4'b0, (i == 6)});
            if (o_s) pulses++;
        end
        chk("post_reset_pulses", 5'(pulses), 5'd1);

        // Randomised levels with occasional asynchronous reset, against the model
        do_reset();
        for (int seg = 0; seg < 500; seg++) begin
            logic rs, rc;
            int len;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                step(rs, rc);
                chk("rand_out", w_out, m_out);
                if (o_s & o_r) chk("rand_s_and_r", {4'b0, o_s & o_r}, 5'b0);
            end
            if ($urandom_range(0, 39) == 0) begin
                i_rst_n = 1'b0;
                #1;
                chk("rand_async_reset", w_out, 5'b0);
                @(posedge i_clk);
                #1;
                i_rst_n = 1'b1;
                model_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
